// File: rtl/present_pkg.sv
// present_pkg: shared constants, S-box and P-box tables, and FSM state type
// for the PRESENT-80 encryption core.
package present_pkg;

    localparam int unsigned SIZE     = 64;
    localparam int unsigned KEY_SIZE = 80;
    localparam int unsigned ROUNDS   = 31;
    localparam int unsigned ROUND_W  = 5;

    // 4-bit S-box, indexed by input nibble
    localparam logic [3:0] SBOX [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    // Forward bit permutation: source bit i lands on PBOX[i] (16*i mod 63, 63 fixed)
    localparam int unsigned PBOX [64] = '{
         0, 16, 32, 48,   1, 17, 33, 49,   2, 18, 34, 50,   3, 19, 35, 51,
         4, 20, 36, 52,   5, 21, 37, 53,   6, 22, 38, 54,   7, 23, 39, 55,
         8, 24, 40, 56,   9, 25, 41, 57,  10, 26, 42, 58,  11, 27, 43, 59,
        12, 28, 44, 60,  13, 29, 45, 61,  14, 30, 46, 62,  15, 31, 47, 63
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/present_sbox.sv
// present_sbox: combinational 4-bit PRESENT S-box.
//   din  - input nibble
//   dout - substituted nibble
module present_sbox
    import present_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = SBOX[din];

endmodule

// File: rtl/present_enc_core.sv
// present_enc_core: iterative PRESENT-80 encryption, one round per clock.
//   clk, rst_n            - clock, async active-low reset
//   in_valid/in_ready     - plaintext+key handshake (ready only in IDLE)
//   plaintext, key        - 64-bit block, 80-bit key (bit 79 = MSB)
//   out_valid/out_ready   - ciphertext handshake (valid only in DONE)
//   ciphertext            - 64-bit result, held stable until transferred
//   busy                  - high in RUN and DONE
module present_enc_core
    import present_pkg::*;
#(
    parameter int unsigned KEY_BITS   = 80,
    parameter int unsigned BLOCK_BITS = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BLOCK_BITS-1:0] plaintext,
    input  logic [KEY_BITS-1:0]   key,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BLOCK_BITS-1:0] ciphertext,
    output logic                  busy
);

    state_t              state;
    logic [SIZE-1:0]     block_q;
    logic [KEY_SIZE-1:0] key_q;
    logic [ROUND_W-1:0]  round_q;

    logic [SIZE-1:0]     ark;
    logic [SIZE-1:0]     sl;
    logic [SIZE-1:0]     pl;
    logic [KEY_SIZE-1:0] key_rot;
    logic [3:0]          key_sb;
    logic [KEY_SIZE-1:0] key_nx;

    // Round datapath: addRoundKey -> sLayer -> pLayer
    assign ark = block_q ^ key_q[KEY_SIZE-1:KEY_SIZE-SIZE];

    for (genvar g = 0; g < 16; g++) begin : g_slayer
        present_sbox u_sbox (
            .din  (ark[4*g +: 4]),
            .dout (sl[4*g +: 4])
        );
    end

    for (genvar g = 0; g < SIZE; g++) begin : g_player
        assign pl[PBOX[g]] = sl[g];
    end

    // Key schedule: rotate left 61 (= right 19), S-box top nibble, XOR round counter
    assign key_rot = {key_q[18:0], key_q[KEY_SIZE-1:19]};

    present_sbox u_key_sbox (
        .din  (key_rot[79:76]),
        .dout (key_sb)
    );

    assign key_nx = {key_sb, key_rot[75:20], key_rot[19:15] ^ round_q, key_rot[14:0]};

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            block_q    <= '0;
            key_q      <= '0;
            round_q    <= '0;
            ciphertext <= '0;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        block_q  <= plaintext;
                        key_q    <= key;
                        round_q  <= ROUND_W'(1);
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    block_q <= pl;
                    key_q   <= key_nx;
                    if (round_q == ROUND_W'(ROUNDS)) begin
                        // final whitening with the 32nd round key
                        ciphertext <= pl ^ key_nx[KEY_SIZE-1:KEY_SIZE-SIZE];
                        out_valid  <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        round_q <= round_q + ROUND_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_present_enc_core.sv
// tb_present_enc_core: directed self-checking bench for present_enc_core.
module tb_present_enc_core;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] plaintext;
    logic [79:0] key;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] ciphertext;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [63:0] vp [4];
    logic [79:0] vk [4];
    logic [63:0] vc [4];

    present_enc_core #(.KEY_BITS(80), .BLOCK_BITS(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ciphertext (ciphertext),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference helpers for the decryption round trip
    function automatic logic [3:0] sb(input logic [3:0] x);
        case (x)
            4'h0: sb = 4'hC; 4'h1: sb = 4'h5; 4'h2: sb = 4'h6; 4'h3: sb = 4'hB;
            4'h4: sb = 4'h9; 4'h5: sb = 4'h0; 4'h6: sb = 4'hA; 4'h7: sb = 4'hD;
            4'h8: sb = 4'h3; 4'h9: sb = 4'hE; 4'hA: sb = 4'hF; 4'hB: sb = 4'h8;
            4'hC: sb = 4'h4; 4'hD: sb = 4'h7; 4'hE: sb = 4'h1; default: sb = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] isb(input logic [3:0] x);
        case (x)
            4'h0: isb = 4'h5; 4'h1: isb = 4'hE; 4'h2: isb = 4'hF; 4'h3: isb = 4'h8;
            4'h4: isb = 4'hC; 4'h5: isb = 4'h1; 4'h6: isb = 4'h2; 4'h7: isb = 4'hD;
            4'h8: isb = 4'hB; 4'h9: isb = 4'h4; 4'hA: isb = 4'h6; 4'hB: isb = 4'h3;
            4'hC: isb = 4'h0; 4'hD: isb = 4'h7; 4'hE: isb = 4'h9; default: isb = 4'hA;
        endcase
    endfunction

    function automatic logic [79:0] kupd(input logic [79:0] k, input logic [4:0] r);
        logic [79:0] t;
        t = {k[18:0], k[79:19]};
        t[79:76] = sb(t[79:76]);
        t[19:15] = t[19:15] ^ r;
        return t;
    endfunction

    function automatic logic [63:0] present_dec(input logic [63:0] c, input logic [79:0] k);
        logic [63:0] rk [33];
        logic [79:0] kk;
        logic [63:0] s;
        logic [63:0] t;
        kk = k;
        rk[1] = kk[79:16];
        for (int i = 1; i <= 31; i++) begin
            kk = kupd(kk, 5'(i));
            rk[i+1] = kk[79:16];
        end
        rk[0] = '0;
        s = c ^ rk[32];
        for (int r = 31; r >= 1; r--) begin
            for (int i = 0; i < 64; i++)
                t[i] = s[(i == 63) ? 63 : ((i * 16) % 63)];
            for (int j = 0; j < 16; j++)
                s[j*4 +: 4] = isb(t[j*4 +: 4]);
            s = s ^ rk[r];
        end
        return s;
    endfunction

    // Accept one block, then count edges until out_valid appears
    task automatic send(input logic [63:0] p, input logic [79:0] k, output int lat);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 50) begin
            @(posedge clk); #1; w++;
        end
        plaintext = p; key = k; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic xfer();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if (out_valid !== 1'b0 || ciphertext !== 64'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: ov=%b ct=%h ir=%b busy=%b expected ov=0 ct=0 ir=1 busy=0",
                     out_valid, ciphertext, in_ready, busy);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL post_reset_ready: ir=%b ov=%b expected ir=1 ov=0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        int lat;
        for (int v = 0; v < 3; v++) begin
            send(vp[v], vk[v], lat);
            total++;
            if (lat !== 31) begin
                bad++;
                $display("FAIL latency_v%0d: got %0d expected 31", v, lat);
            end
            total++;
            if (ciphertext !== vc[v]) begin
                bad++;
                $display("FAIL cipher_v%0d: got %h expected %h", v, ciphertext, vc[v]);
            end
            total++;
            if (busy !== 1'b1 || in_ready !== 1'b0) begin
                bad++;
                $display("FAIL done_flags_v%0d: busy=%b ir=%b expected busy=1 ir=0", v, busy, in_ready);
            end
            xfer();
            total++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL after_xfer_v%0d: ov=%b ir=%b busy=%b expected 0 1 0",
                         v, out_valid, in_ready, busy);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        int errs;
        int extra;
        send(vp[3], vk[3], lat);
        total++;
        if (lat !== 31 || ciphertext !== vc[3]) begin
            bad++;
            $display("FAIL bp_result: lat=%0d ct=%h expected lat=31 ct=%h", lat, ciphertext, vc[3]);
        end
        errs = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            plaintext = {$urandom, $urandom};
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || ciphertext !== vc[3]) errs++;
        end
        in_valid = 1'b0;
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL bp_hold: %0d bad cycles, ct=%h expected stable %h with ir=0", errs, ciphertext, vc[3]);
        end
        xfer();
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) extra++;
        end
        total++;
        if (extra != 0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_single_xfer: extra_valid_cycles=%0d ir=%b expected 0 and ir=1", extra, in_ready);
        end
    endtask

    task automatic test_toggle_inputs();
        int lat;
        int extra;
        plaintext = vp[0]; key = vk[0]; in_valid = 1'b1;
        @(posedge clk); #1;
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            in_valid = ~in_valid;
            plaintext = {$urandom, $urandom};
            key = {16'($urandom), $urandom, $urandom};
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        for (int n = 21; n <= 60; n++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
        total++;
        if (lat !== 31 || ciphertext !== vc[0]) begin
            bad++;
            $display("FAIL toggle_result: lat=%0d ct=%h expected lat=31 ct=%h", lat, ciphertext, vc[0]);
        end
        xfer();
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) extra++;
        end
        total++;
        if (extra != 0) begin
            bad++;
            $display("FAIL toggle_single_output: extra_valid_cycles=%0d expected 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        plaintext = vp[1]; key = vk[1]; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || ciphertext !== 64'h0) begin
            bad++;
            $display("FAIL reset_mid_run: ov=%b busy=%b ir=%b ct=%h expected 0 0 1 0",
                     out_valid, busy, in_ready, ciphertext);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_release: ir=%b expected 1", in_ready);
        end
        // reset while holding a finished block in DONE
        send(vp[2], vk[2], lat);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || ciphertext !== 64'h0) begin
            bad++;
            $display("FAIL reset_in_done: ov=%b ct=%h expected ov=0 ct=0", out_valid, ciphertext);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        send(vp[2], vk[2], lat);
        total++;
        if (lat !== 31 || ciphertext !== vc[2]) begin
            bad++;
            $display("FAIL reset_next_vector: lat=%0d ct=%h expected lat=31 ct=%h", lat, ciphertext, vc[2]);
        end
        xfer();
    endtask

    task automatic test_back_to_back();
        logic [63:0] got [4];
        int          acc [4];
        int          nacc;
        int          nout;
        int          cyc;
        logic        ir;
        logic        iv;
        logic        ov;
        logic [63:0] ct;
        logic [63:0] dec;
        nacc = 0; nout = 0; cyc = 0;
        out_ready = 1'b1;
        plaintext = vp[0]; key = vk[0]; in_valid = 1'b1;
        while (nout < 4 && cyc < 300) begin
            @(negedge clk);
            ir = in_ready; iv = in_valid; ov = out_valid; ct = ciphertext;
            @(posedge clk);
            cyc++;
            if (ov) begin
                got[nout] = ct;
                nout++;
            end
            if (ir && iv) begin
                acc[nacc] = cyc;
                nacc++;
                #1;
                if (nacc < 4) begin
                    plaintext = vp[nacc]; key = vk[nacc];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        total++;
        if (nout != 4) begin
            bad++;
            $display("FAIL b2b_timeout: outputs=%0d expected 4", nout);
        end
        for (int i = 0; i < nout; i++) begin
            total++;
            if (got[i] !== vc[i]) begin
                bad++;
                $display("FAIL b2b_cipher_%0d: got %h expected %h", i, got[i], vc[i]);
            end
            dec = present_dec(got[i], vk[i]);
            total++;
            if (dec !== vp[i]) begin
                bad++;
                $display("FAIL b2b_roundtrip_%0d: got %h expected %h", i, dec, vp[i]);
            end
        end
        for (int i = 1; i < nacc; i++) begin
            total++;
            if (acc[i] - acc[i-1] < 32 || acc[i] - acc[i-1] > 33) begin
                bad++;
                $display("FAIL b2b_spacing_%0d: got %0d cycles expected 32..33", i, acc[i] - acc[i-1]);
            end
        end
    endtask

    initial begin
        vp[0] = 64'h0000000000000000; vk[0] = 80'h00000000000000000000; vc[0] = 64'h5579C1387B228445;
        vp[1] = 64'h0000000000000000; vk[1] = 80'hFFFFFFFFFFFFFFFFFFFF; vc[1] = 64'hE72C46C0F5945049;
        vp[2] = 64'hFFFFFFFFFFFFFFFF; vk[2] = 80'h00000000000000000000; vc[2] = 64'hA112FFC72F68417B;
        vp[3] = 64'hFFFFFFFFFFFFFFFF; vk[3] = 80'hFFFFFFFFFFFFFFFFFFFF; vc[3] = 64'h3333DCD3213210D2;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        plaintext = '0; key = '0;
        #12;

        test_reset();
        test_vectors();
        test_backpressure();
        test_toggle_inputs();
        test_reset_mid();
        test_back_to_back();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
